// File: rtl/pb_press_classifier.sv
// Multi-channel push-button front end: synchronise, debounce and classify each
// button as a short or long press. Channels are independent; only any_long
// combines them into a one-shot reset request.
module pb_press_classifier #(
    parameter int unsigned N_CH         = 4,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned LONG_CYC     = 200000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] pb_level,
    output logic [N_CH-1:0] pb_short,
    output logic [N_CH-1:0] pb_long,
    output logic [N_CH-1:0] pb_held,
    output logic            any_long
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_LONG
    } state_e;

    // Normalised pressed level: 1 means pressed for either pin polarity.
    logic [N_CH-1:0] pressed;
    logic [N_CH-1:0] long_fire;

    assign pressed = pb_in ^ {N_CH{ACTIVE_LOW}};

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic              sync1_q;
        logic              sync2_q;
        logic [DB_W-1:0]   db_cnt_q;
        logic              level_q;
        state_e            state_q;
        logic [HOLD_W-1:0] hold_q;
        logic              short_q;
        logic              long_q;
        logic              held_q;

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= pressed[ch];
                sync2_q <= sync1_q;
            end
        end

        // Accept a level change only after DEBOUNCE_CYC consecutive differing samples.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt_q <= '0;
                level_q  <= 1'b0;
            end else if (sync2_q == level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_q  <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end

        // Same condition the FSM uses to raise pb_long, shared so any_long lines up with it.
        assign long_fire[ch] = (state_q == ST_PRESS) && level_q && (hold_q == HOLD_LAST);

        // Press classifier; release is checked first so it wins at the long boundary.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                hold_q  <= '0;
                short_q <= 1'b0;
                long_q  <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                short_q <= 1'b0;
                long_q  <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (level_q) begin
                            state_q <= ST_PRESS;
                            hold_q  <= HOLD_W'(1);
                        end
                    end
                    ST_PRESS: begin
                        if (!level_q) begin
                            state_q <= ST_IDLE;
                            short_q <= 1'b1;
                        end else if (hold_q == HOLD_LAST) begin
                            state_q <= ST_LONG;
                            long_q  <= 1'b1;
                            held_q  <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    ST_LONG: begin
                        if (!level_q) begin
                            state_q <= ST_IDLE;
                            held_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign pb_level[ch] = level_q;
        assign pb_short[ch] = short_q;
        assign pb_long[ch]  = long_q;
        assign pb_held[ch]  = held_q;
    end

    // Registered OR of the per-channel long events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_long <= 1'b0;
        end else begin
            any_long <= |long_fire;
        end
    end

endmodule

// File: tb/tb_pb_press_classifier.sv
// Bench for pb_press_classifier: two instances (active-low and active-high pins,
// fed complementary stimulus) compared every cycle against a history-based model.
module tb_pb_press_classifier;

    localparam int unsigned NCH  = 2;
    localparam int          DB   = 4;
    localparam int          LG   = 20;
    localparam int          MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pb_in_al = 2'b11;
    logic [1:0] pb_in_ah = 2'b00;

    logic [1:0] al_level, al_short, al_long, al_held;
    logic       al_any;
    logic [1:0] ah_level, ah_short, ah_long, ah_held;
    logic       ah_any;

    pb_press_classifier #(
        .N_CH(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(4), .LONG_CYC(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_in_al),
        .pb_level(al_level), .pb_short(al_short), .pb_long(al_long),
        .pb_held(al_held), .any_long(al_any)
    );

    pb_press_classifier #(
        .N_CH(2), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYC(4), .LONG_CYC(20)
    ) dut_h (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_in_ah),
        .pb_level(ah_level), .pb_short(ah_short), .pb_long(ah_long),
        .pb_held(ah_held), .any_long(ah_any)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   t = 0;
    logic hist [NCH][MAXC];   // pressed value present between edge c and c+1
    logic lvl  [NCH][MAXC];   // expected debounced level after edge c
    int   n_short [NCH];
    int   n_long  [NCH];
    logic [1:0] seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    // Synchronised sample after edge idx: the pin two cycles earlier, 0 out of reset.
    function automatic logic s_at(int ch, int idx);
        if (idx >= 2) return hist[ch][idx-2];
        return 1'b0;
    endfunction

    // Length of the run of pressed levels ending at edge idx, capped just past LG.
    function automatic int ones_ending(int ch, int idx);
        int n = 0;
        for (int k = idx; k >= 0 && n <= LG; k--) begin
            if (lvl[ch][k]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_edge(output logic [1:0] e_lvl, output logic [1:0] e_sh,
                              output logic [1:0] e_lg, output logic [1:0] e_hd);
        e_lvl = '0; e_sh = '0; e_lg = '0; e_hd = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            logic prev;
            logic flip;
            int   run;
            int   prun;
            prev = lvl[ch][t-1];
            flip = 1'b1;
            for (int k = 1; k <= DB; k++)
                if (s_at(ch, t - k) === prev) flip = 1'b0;
            lvl[ch][t] = flip ? ~prev : prev;
            run  = ones_ending(ch, t - 1);
            prun = (t >= 2) ? ones_ending(ch, t - 2) : 0;
            e_lvl[ch] = lvl[ch][t];
            e_lg[ch]  = (run == LG);
            e_hd[ch]  = (run >= LG);
            e_sh[ch]  = !lvl[ch][t-1] && (prun > 0) && (prun < LG);
        end
    endtask

    task automatic step(input logic [1:0] press);
        logic [1:0] el, es, eg, eh;
        if (t >= MAXC - 1) begin
            $display("FAIL model_overflow t=%0d got=%0d exp<%0d", t, t, MAXC - 1);
            $fatal(1, "model history exhausted");
        end
        pb_in_al = ~press;
        pb_in_ah = press;
        for (int ch = 0; ch < NCH; ch++) hist[ch][t] = press[ch];
        @(posedge clk);
        t++;
        model_edge(el, es, eg, eh);
        #1;
        check("lvl_al",   32'(al_level), 32'(el));
        check("short_al", 32'(al_short), 32'(es));
        check("long_al",  32'(al_long),  32'(eg));
        check("held_al",  32'(al_held),  32'(eh));
        check("any_al",   32'(al_any),   32'(|eg));
        check("lvl_ah",   32'(ah_level), 32'(el));
        check("short_ah", 32'(ah_short), 32'(es));
        check("long_ah",  32'(ah_long),  32'(eg));
        check("held_ah",  32'(ah_held),  32'(eh));
        check("any_ah",   32'(ah_any),   32'(|eg));
        for (int ch = 0; ch < NCH; ch++) begin
            if (al_short[ch]) n_short[ch]++;
            if (al_long[ch])  n_long[ch]++;
        end
        seen = seen | al_level | al_short | al_long;
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < NCH; ch++) begin
            n_short[ch] = 0;
            n_long[ch]  = 0;
        end
        seen = '0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        for (int ch = 0; ch < NCH; ch++) lvl[ch][0] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout t=%0d got=running exp=finished", t);
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        logic [1:0] cur;
        int         rem [NCH];

        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check("reset_al", 32'({al_level, al_short, al_long, al_held, al_any}), 32'd0);
        check("reset_ah", 32'({ah_level, ah_short, ah_long, ah_held, ah_any}), 32'd0);
        release_reset();

        // Debounce latency on both edges, single short pulse on release.
        for (int i = 0; i < 25; i++) begin
            step((i < 10) ? 2'b01 : 2'b00);
            if (i == 4)  check("lat_rise_pre", 32'(al_level[0]), 32'd0);
            if (i == 5)  check("lat_rise",     32'(al_level[0]), 32'd1);
            if (i == 14) check("lat_fall_pre", 32'(al_level[0]), 32'd1);
            if (i == 15) check("lat_fall",     32'(al_level[0]), 32'd0);
            if (i == 16) check("short_at",     32'(al_short[0]), 32'd1);
            if (i == 17) check("short_once",   32'(al_short[0]), 32'd0);
        end

        // Glitches shorter than the debounce window never reach the outputs.
        clear_counts();
        repeat (5) begin
            repeat (3) step(2'b10);
            repeat (3) step(2'b00);
        end
        repeat (10) step(2'b00);
        check("glitch_ch1", 32'(seen[1]), 32'd0);

        // Long press: exactly one pb_long, no pb_short.
        clear_counts();
        for (int i = 0; i < 60; i++) begin
            step((i < 40) ? 2'b01 : 2'b00);
            if (i == 25) check("any_long_at",   32'(al_any), 32'd1);
            if (i == 26) check("any_long_once", 32'(al_any), 32'd0);
        end
        check("long_cnt",  32'(n_long[0]),  32'd1);
        check("long_noshort", 32'(n_short[0]), 32'd0);

        // Boundary: 19-cycle press is short, 20-cycle press is long.
        clear_counts();
        repeat (19) step(2'b01);
        repeat (30) step(2'b00);
        check("b19_short", 32'(n_short[0]), 32'd1);
        check("b19_long",  32'(n_long[0]),  32'd0);
        clear_counts();
        repeat (20) step(2'b01);
        repeat (30) step(2'b00);
        check("b20_short", 32'(n_short[0]), 32'd0);
        check("b20_long",  32'(n_long[0]),  32'd1);

        // Channel independence: ch0 long while ch1 short.
        clear_counts();
        for (int i = 0; i < 60; i++)
            step({(i >= 5 && i < 15) ? 1'b1 : 1'b0, (i < 40) ? 1'b1 : 1'b0});
        check("ind_ch0_long",  32'(n_long[0]),  32'd1);
        check("ind_ch0_short", 32'(n_short[0]), 32'd0);
        check("ind_ch1_long",  32'(n_long[1]),  32'd0);
        check("ind_ch1_short", 32'(n_short[1]), 32'd1);

        // Randomised press/release durations around every threshold.
        cur = 2'b00;
        for (int ch = 0; ch < NCH; ch++) rem[ch] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (rem[ch] == 0) begin
                    cur[ch] = ~cur[ch];
                    case ($urandom_range(0, 3))
                        0:       rem[ch] = $urandom_range(1, 5);
                        1:       rem[ch] = $urandom_range(6, 18);
                        2:       rem[ch] = $urandom_range(19, 21);
                        default: rem[ch] = $urandom_range(22, 45);
                    endcase
                end
                rem[ch]--;
            end
            step(cur);
        end
        repeat (40) step(2'b00);

        // Asynchronous reset in the middle of a press.
        repeat (15) step(2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_al", 32'({al_level, al_short, al_long, al_held, al_any}), 32'd0);
        check("arst_ah", 32'({ah_level, ah_short, ah_long, ah_held, ah_any}), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        clear_counts();
        for (int i = 0; i < 60; i++) begin
            step((i < 40) ? 2'b11 : 2'b00);
            if (i == 4)  check("arst_rise_pre", 32'(al_level), 32'd0);
            if (i == 5)  check("arst_rise",     32'(al_level), 32'd3);
            if (i == 25) check("arst_long",     32'(al_long),  32'd3);
        end
        check("arst_long_cnt", 32'(n_long[0]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pb_press_classifier.md
Name: pb_press_classifier

Overview:
- Multi-channel push-button front end. Synchronises, debounces and classifies each button as a short press or a long press.
- Generalises the single long-press reset pulse generator: N channels, selectable input polarity, true debouncing, separate short/long events, and a held-long level.
- Sits between the board push-button pins and the game/control FSMs.
- A long press on any channel can drive a one-shot reset request.

Parameters:
- N_CH, 4, number of independent button channels.
- ACTIVE_LOW, 1, 1 = pin low means pressed (board buttons); 0 = pin high means pressed.
- DEBOUNCE_CYC, 50000, consecutive stable synchronised samples needed to accept a level change; must be >= 1.
- LONG_CYC, 200000000, debounced-press duration in cycles that classifies a long press; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pb_in  input  N_CH  raw button pins, asynchronous to clk.
- pb_level  output  N_CH  debounced pressed level, active-high regardless of ACTIVE_LOW.
- pb_short  output  N_CH  one-cycle pulse on release of a press shorter than LONG_CYC.
- pb_long  output  N_CH  one-cycle pulse when a press reaches LONG_CYC.
- pb_held  output  N_CH  high from the pb_long pulse until release.
- any_long  output  1  OR of pb_long across channels (reset-request pulse).

Behaviour:
- Channels are fully independent; all logic is replicated per channel. Only any_long combines channels.
- Reset (rst_n low, asynchronous):
  - All outputs go to 0.
  - Synchroniser flops go to the "not pressed" value.
  - Debounce and hold counters go to 0.
  - FSM goes to IDLE.
- Reset release mid-press: the channel restarts from IDLE. The press is only seen after full debounce latency, and hold timing starts fresh.
- Polarity: p = pb_in XOR ACTIVE_LOW, so p = 1 means pressed.
- Synchroniser: p passes through a 2-flop chain to give s.
- Debounce:
  - Counter db_cnt, width $clog2(DEBOUNCE_CYC+1).
  - If s == pb_level, db_cnt is cleared.
  - Otherwise db_cnt increments. On the edge where db_cnt == DEBOUNCE_CYC-1, pb_level <= s and db_cnt <= 0.
  - Any glitch shorter than DEBOUNCE_CYC cycles is rejected, and the counter restarts.
  - Latency from pin edge to pb_level change: 2 + DEBOUNCE_CYC cycles.
- Classifier FSM per channel, driven by pb_level:
  - Hold counter hold_cnt, width $clog2(LONG_CYC+1). It saturates; no wrap-around is possible.
  - IDLE: pb_level = 1 → PRESS, hold_cnt <= 1.
  - PRESS:
    - pb_level = 0 → IDLE; pb_short = 1 for the next cycle only.
    - Else, if hold_cnt == LONG_CYC-1 → LONG; pb_long = 1 for one cycle; pb_held <= 1.
    - Else hold_cnt increments.
  - LONG:
    - pb_level = 0 → IDLE; pb_held <= 0; no pb_short.
    - Held indefinitely: stays in LONG, and no further pb_long pulses occur.
- Pulse timing:
  - pb_long is high exactly LONG_CYC cycles after the cycle pb_level rose.
  - pb_short is high the cycle after pb_level falls.
  - pb_short and pb_long are never both high on one channel for the same press.
- Boundary case: release arrives on the same edge the count reaches LONG_CYC-1. Release wins: pb_short, no pb_long.
- All outputs are registered; there are no combinational paths from pb_in.
- Counters and FSM are clocked only by clk; no derived clocks.

Test Plan:
- Bench parameters: N_CH=2, ACTIVE_LOW=1, DEBOUNCE_CYC=4, LONG_CYC=20, unless noted.
- Debounce latency: drive pb_in[0] low at cycle 0 and hold → pb_level[0] rises at cycle 6. Drive it high at cycle 10 → pb_level[0] falls at cycle 16, with pb_short[0] high at cycle 17 only.
- Glitch rejection: pulse pb_in[1] low for 3 cycles, repeated 5 times with 3-cycle gaps → pb_level[1], pb_short[1] and pb_long[1] stay 0 throughout.
- Long press: hold pb_in[0] low for 40 cycles → pb_level rises at cycle 6. Then:
  - pb_long[0] and any_long high at cycle 26 only.
  - pb_held[0] high from 26 until pb_level falls.
  - No pb_short[0] on release.
- Short/long boundary: debounced press of 19 cycles → one pb_short pulse, no pb_long. Debounced press of 20 cycles → pb_long, no pb_short.
- Channel independence and polarity:
  - Channel 0 held long while channel 1 is pressed short → channel 0 gives only pb_long, channel 1 gives only pb_short.
  - Repeat with ACTIVE_LOW=0 and inverted stimulus → identical outputs.
- Async reset mid-press: assert rst_n low at cycle 15 of a long press, between clock edges → all outputs 0 immediately. Release rst_n with the pin still pressed → pb_level re-rises 6 cycles later, and pb_long follows 20 cycles after that.
